// File: rtl/mprj_io_filter.sv
// Per-pad input conditioning: N-stage synchroniser, debounce filter, edge detect and sticky W1C interrupt status.
// Optional level-interrupt mode is compiled in with `define MPRJ_IO_FILTER_LEVEL_EN (adds the level_en port).
module mprj_io_filter #(
    parameter int NUM_PADS    = 38,
    parameter int SYNC_STAGES = 2,
    parameter int DB_WIDTH    = 8
) (
    input  logic                wb_clk_i,
    input  logic                wb_rst_i,
    input  logic [NUM_PADS-1:0] pad_in,
    input  logic [NUM_PADS-1:0] inp_dis,
    input  logic [DB_WIDTH-1:0] db_limit,
`ifdef MPRJ_IO_FILTER_LEVEL_EN
    input  logic [NUM_PADS-1:0] level_en,
`endif
    input  logic [NUM_PADS-1:0] rise_en,
    input  logic [NUM_PADS-1:0] fall_en,
    input  logic [NUM_PADS-1:0] status_clr,
    output logic [NUM_PADS-1:0] io_in_sync,
    output logic [NUM_PADS-1:0] io_in_filt,
    output logic [NUM_PADS-1:0] irq_status,
    output logic                irq
);

    logic [NUM_PADS-1:0] sync_r [SYNC_STAGES];
    logic [DB_WIDTH-1:0] cnt_r  [NUM_PADS];
    logic [DB_WIDTH-1:0] cnt_nxt_s [NUM_PADS];
    logic [NUM_PADS-1:0] filt_r;
    logic [NUM_PADS-1:0] filt_nxt_s;
    logic [NUM_PADS-1:0] filt_q_r;
    logic [NUM_PADS-1:0] status_r;
    logic [NUM_PADS-1:0] set_s;
    logic [DB_WIDTH-1:0] lim_m1_s;

    assign io_in_sync = sync_r[SYNC_STAGES-1];
    assign io_in_filt = filt_r;
    assign irq_status = status_r;
    assign irq        = |status_r;

    // Synchroniser chain; disabled pads are forced low at the first stage.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            for (int s = 0; s < SYNC_STAGES; s++) begin
                sync_r[s] <= {NUM_PADS{1'b0}};
            end
        end else begin
            sync_r[0] <= pad_in & ~inp_dis;
            for (int s = 1; s < SYNC_STAGES; s++) begin
                sync_r[s] <= sync_r[s-1];
            end
        end
    end

    // Effective terminal count L-1, with a zero limit treated as one.
    always_comb begin
        lim_m1_s = {DB_WIDTH{1'b0}};
        if (db_limit == {DB_WIDTH{1'b0}}) begin
            lim_m1_s = {DB_WIDTH{1'b0}};
        end else begin
            lim_m1_s = db_limit - DB_WIDTH'(1);
        end
    end

    // Debounce next-state; >= lets a lowered limit commit an already-long mismatch at once.
    always_comb begin
        filt_nxt_s = filt_r;
        for (int i = 0; i < NUM_PADS; i++) begin
            cnt_nxt_s[i] = {DB_WIDTH{1'b0}};
            if (sync_r[SYNC_STAGES-1][i] == filt_r[i]) begin
                cnt_nxt_s[i] = {DB_WIDTH{1'b0}};
            end else if (cnt_r[i] >= lim_m1_s) begin
                filt_nxt_s[i] = sync_r[SYNC_STAGES-1][i];
                cnt_nxt_s[i]  = {DB_WIDTH{1'b0}};
            end else begin
                cnt_nxt_s[i] = cnt_r[i] + DB_WIDTH'(1);
            end
        end
    end

    // Debounce counters and filtered level.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            filt_r <= {NUM_PADS{1'b0}};
            for (int i = 0; i < NUM_PADS; i++) begin
                cnt_r[i] <= {DB_WIDTH{1'b0}};
            end
        end else begin
            filt_r <= filt_nxt_s;
            for (int i = 0; i < NUM_PADS; i++) begin
                cnt_r[i] <= cnt_nxt_s[i];
            end
        end
    end

    // Qualified edge (and optional level) events that set the status bits.
    always_comb begin
        set_s = (filt_r & ~filt_q_r & rise_en) | (~filt_r & filt_q_r & fall_en);
`ifdef MPRJ_IO_FILTER_LEVEL_EN
        set_s = set_s | (filt_r & level_en);
`endif
    end

    // Edge-detect delay and sticky status; a coincident set beats the clear.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            filt_q_r <= {NUM_PADS{1'b0}};
            status_r <= {NUM_PADS{1'b0}};
        end else begin
            filt_q_r <= filt_r;
            status_r <= (status_r & ~status_clr) | set_s;
        end
    end

endmodule

// File: tb/tb_mprj_io_filter.sv
// Directed self-checking bench for mprj_io_filter with hand-computed cycle expectations.
module tb_mprj_io_filter;

    localparam int NP = 38;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NP-1:0] pad_in, inp_dis, rise_en, fall_en, status_clr;
    logic [DW-1:0] db_limit;
    logic [NP-1:0] io_in_sync, io_in_filt, irq_status;
    logic          irq;
`ifdef MPRJ_IO_FILTER_LEVEL_EN
    logic [NP-1:0] level_en;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int cnt_hi;
    logic seen;

    mprj_io_filter #(.NUM_PADS(NP), .SYNC_STAGES(2), .DB_WIDTH(DW)) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .pad_in     (pad_in),
        .inp_dis    (inp_dis),
        .db_limit   (db_limit),
`ifdef MPRJ_IO_FILTER_LEVEL_EN
        .level_en   (level_en),
`endif
        .rise_en    (rise_en),
        .fall_en    (fall_en),
        .status_clr (status_clr),
        .io_in_sync (io_in_sync),
        .io_in_filt (io_in_filt),
        .irq_status (irq_status),
        .irq        (irq)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_all();
        status_clr = {NP{1'b1}};
        tick(1);
        status_clr = {NP{1'b0}};
    endtask

    initial begin
        rst = 1'b1; pad_in = '0; inp_dis = '0; rise_en = '0; fall_en = '0;
        status_clr = '0; db_limit = 8'd4;
`ifdef MPRJ_IO_FILTER_LEVEL_EN
        level_en = '0;
`endif
        tick(3);
        rst = 1'b0;
        tick(1);
        check_eq("rst_sync", io_in_sync, 0);
        check_eq("rst_filt", io_in_filt, 0);
        check_eq("rst_stat", irq_status, 0);
        check_eq("rst_irq", irq, 0);

        // Basic latency: L=4, pad 0 rising
        rise_en[0] = 1'b1;
        pad_in[0] = 1'b1;
        tick(1);
        check_eq("p0_sync_c1", io_in_sync[0], 0);
        tick(1);
        check_eq("p0_sync_c2", io_in_sync[0], 1);
        tick(3);
        check_eq("p0_filt_c5", io_in_filt[0], 0);
        tick(1);
        check_eq("p0_filt_c6", io_in_filt[0], 1);
        check_eq("p0_stat_c6", irq_status[0], 0);
        tick(1);
        check_eq("p0_stat_c7", irq_status[0], 1);
        check_eq("p0_irq_c7", irq, 1);
        clear_all();
        check_eq("p0_cleared", irq_status, 0);

        // 3-cycle glitch on pad 5 is absorbed
        rise_en[5] = 1'b1; fall_en[5] = 1'b1;
        pad_in[5] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 14; k++) begin
            if (k == 3) pad_in[5] = 1'b0;
            tick(1);
            seen = seen | io_in_filt[5];
        end
        check_eq("p5_glitch_filt", seen, 0);
        check_eq("p5_glitch_stat", irq_status[5], 0);

        // 4-cycle pulse passes for exactly 4 cycles; fall flag only
        rise_en[5] = 1'b0;
        pad_in[5] = 1'b1;
        cnt_hi = 0;
        for (int k = 0; k < 20; k++) begin
            if (k == 4) pad_in[5] = 1'b0;
            tick(1);
            if (io_in_filt[5]) cnt_hi++;
        end
        check_eq("p5_pulse_width", cnt_hi, 4);
        check_eq("p5_fall_flag", irq_status[5], 1);
        fall_en[5] = 1'b0;
        clear_all();

        // db_limit=0 behaves as 1 on the top pad
        db_limit = 8'd0;
        pad_in[37] = 1'b1;
        tick(2);
        check_eq("p37_sync_up", io_in_sync[37], 1);
        check_eq("p37_filt_c2", io_in_filt[37], 0);
        tick(1);
        check_eq("p37_filt_up", io_in_filt[37], 1);
        pad_in[37] = 1'b0;
        tick(2);
        check_eq("p37_filt_hold", io_in_filt[37], 1);
        tick(1);
        check_eq("p37_filt_dn", io_in_filt[37], 0);

        // Set beats coincident clear on pad 3, then a lone clear wins
        rise_en[3] = 1'b1;
        pad_in[3] = 1'b1;
        tick(4);
        check_eq("p3_first_set", irq_status[3], 1);
        pad_in[3] = 1'b0;
        tick(5);
        pad_in[3] = 1'b1;
        tick(3);
        status_clr[3] = 1'b1;
        tick(1);
        status_clr[3] = 1'b0;
        check_eq("p3_set_wins", irq_status[3], 1);
        tick(2);
        status_clr[3] = 1'b1;
        tick(1);
        status_clr[3] = 1'b0;
        check_eq("p3_lone_clr", irq_status[3], 0);
        check_eq("p3_irq_low", irq, 0);

        // Input disable on a high pad: filt falls after 2+L, no flag with fall_en=0
        db_limit = 8'd4;
        pad_in[2] = 1'b1;
        tick(8);
        check_eq("p2_filt_high", io_in_filt[2], 1);
        inp_dis[2] = 1'b1;
        tick(5);
        check_eq("p2_dis_c5", io_in_filt[2], 1);
        tick(1);
        check_eq("p2_dis_c6", io_in_filt[2], 0);
        tick(2);
        check_eq("p2_dis_stat", irq_status[2], 0);

        // Reset mid-debounce on pad 4 discards the count
        rise_en[4] = 1'b1;
        pad_in[4] = 1'b1;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check_eq("rst_mid_filt", io_in_filt, 0);
        check_eq("rst_mid_sync", io_in_sync, 0);
        tick(1);
        check_eq("rst_mid_noflag", irq_status, 0);
        tick(4);
        check_eq("p4_after_rst_c5", io_in_filt[4], 0);
        tick(1);
        check_eq("p4_after_rst_c6", io_in_filt[4], 1);
        tick(1);
        check_eq("p4_after_rst_stat", irq_status[4], 1);
        clear_all();

`ifdef MPRJ_IO_FILTER_LEVEL_EN
        level_en[1] = 1'b1;
        pad_in[1] = 1'b1;
        tick(7);
        check_eq("lvl_set", irq_status[1], 1);
        for (int k = 0; k < 2; k++) begin
            status_clr[1] = 1'b1;
            tick(1);
            status_clr[1] = 1'b0;
            check_eq("lvl_clr_blocked", irq_status[1], 1);
        end
        pad_in[1] = 1'b0;
        tick(8);
        check_eq("lvl_filt_low", io_in_filt[1], 0);
        status_clr[1] = 1'b1;
        tick(1);
        status_clr[1] = 1'b0;
        check_eq("lvl_clr_ok", irq_status[1], 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
